// File: rtl/regfile_wb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : regfile_wb
// Brief    : Integer register file (x0 hardwired to zero) with two registered
//            read ports and a same-cycle writeback-to-decode bypass.
// Revision : 1.0
// ============================================================================
module regfile_wb #(
    parameter int XLEN   = 32,
    parameter int REGNUM = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            phase_decode,
    input  logic            phase_writeback,
    input  logic [4:0]      rs1sel_fr,
    input  logic [4:0]      rs2sel_fr,
    input  logic [4:0]      rdsel_wr,
    input  logic [XLEN-1:0] rddata_wr,
    output logic [XLEN-1:0] rs1data_rd,
    output logic [XLEN-1:0] rs2data_rd,
    output logic            wr_valid_rd
);

    localparam logic [4:0] c_x0 = 5'd0;

    logic [XLEN-1:0] r_reg_q [1:REGNUM-1];
    logic [XLEN-1:0] w_reg_d [1:REGNUM-1];
    logic [XLEN-1:0] w_regs  [0:REGNUM-1];

    logic            w_we;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_rs1data_d;
    logic [XLEN-1:0] w_rs2data_d;
    logic            w_wr_valid_d;
    logic [XLEN-1:0] r_rs1data_q;
    logic [XLEN-1:0] r_rs2data_q;
    logic            r_wr_valid_q;

    // rdsel 0 encodes "no destination", so it never commits nor pulses valid.
    assign w_we = phase_writeback && (rdsel_wr != c_x0);

    assign w_regs[0] = '0;

    generate
        for (genvar i = 1; i < REGNUM; i++) begin : g_regs
            localparam logic [4:0] c_idx = 5'(i);

            always_comb begin
                w_reg_d[i] = r_reg_q[i];
                if (w_we && (rdsel_wr == c_idx)) begin
                    w_reg_d[i] = rddata_wr;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_reg_q[i] <= '0;
                end else begin
                    r_reg_q[i] <= w_reg_d[i];
                end
            end

            assign w_regs[i] = r_reg_q[i];
        end
    endgenerate

    // Writeback data in flight wins over the stored copy for each port.
    always_comb begin
        w_rs1_val = w_regs[rs1sel_fr];
        if (rs1sel_fr == c_x0) begin
            w_rs1_val = '0;
        end else if (phase_writeback && (rdsel_wr == rs1sel_fr)) begin
            w_rs1_val = rddata_wr;
        end
    end

    always_comb begin
        w_rs2_val = w_regs[rs2sel_fr];
        if (rs2sel_fr == c_x0) begin
            w_rs2_val = '0;
        end else if (phase_writeback && (rdsel_wr == rs2sel_fr)) begin
            w_rs2_val = rddata_wr;
        end
    end

    always_comb begin
        w_rs1data_d  = r_rs1data_q;
        w_rs2data_d  = r_rs2data_q;
        w_wr_valid_d = w_we;
        if (phase_decode) begin
            w_rs1data_d = w_rs1_val;
            w_rs2data_d = w_rs2_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1data_q  <= '0;
            r_rs2data_q  <= '0;
            r_wr_valid_q <= 1'b0;
        end else begin
            r_rs1data_q  <= w_rs1data_d;
            r_rs2data_q  <= w_rs2data_d;
            r_wr_valid_q <= w_wr_valid_d;
        end
    end

    assign rs1data_rd  = r_rs1data_q;
    assign rs2data_rd  = r_rs2data_q;
    assign wr_valid_rd = r_wr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_regfile_wb
// Brief    : Directed and randomized checks of regfile_wb against a model.
// Revision : 1.0
// ============================================================================
module tb_regfile_wb;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            phase_decode;
    logic            phase_writeback;
    logic [4:0]      rs1sel_fr;
    logic [4:0]      rs2sel_fr;
    logic [4:0]      rdsel_wr;
    logic [XLEN-1:0] rddata_wr;
    logic [XLEN-1:0] rs1data_rd;
    logic [XLEN-1:0] rs2data_rd;
    logic            wr_valid_rd;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] m_regs [32];
    logic [XLEN-1:0] m_rs1;
    logic [XLEN-1:0] m_rs2;
    logic            m_wv;

    regfile_wb #(.XLEN(XLEN), .REGNUM(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .phase_decode    (phase_decode),
        .phase_writeback (phase_writeback),
        .rs1sel_fr       (rs1sel_fr),
        .rs2sel_fr       (rs2sel_fr),
        .rdsel_wr        (rdsel_wr),
        .rddata_wr       (rddata_wr),
        .rs1data_rd      (rs1data_rd),
        .rs2data_rd      (rs2data_rd),
        .wr_valid_rd     (wr_valid_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] model_value(input logic [4:0] sel);
        if (sel == 5'd0) return '0;
        if (phase_writeback && rdsel_wr == sel) return rddata_wr;
        return m_regs[sel];
    endfunction

    // Advance the model by one edge using the current inputs, then step the
    // clock and settle 1ns past the edge so outputs can be sampled.
    task automatic cycle();
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
        if (rst) begin
            foreach (m_regs[k]) m_regs[k] = '0;
            m_rs1 = '0;
            m_rs2 = '0;
            m_wv  = 1'b0;
        end else begin
            v1 = model_value(rs1sel_fr);
            v2 = model_value(rs2sel_fr);
            if (phase_decode) begin
                m_rs1 = v1;
                m_rs2 = v2;
            end
            m_wv = phase_writeback && (rdsel_wr != 5'd0);
            if (m_wv) m_regs[rdsel_wr] = rddata_wr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; phase_decode = 1'b0; phase_writeback = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] sel, input logic [XLEN-1:0] data);
        idle();
        phase_writeback = 1'b1; rdsel_wr = sel; rddata_wr = data;
        cycle();
        phase_writeback = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] s1, input logic [4:0] s2);
        idle();
        phase_decode = 1'b1; rs1sel_fr = s1; rs2sel_fr = s2;
        cycle();
        phase_decode = 1'b0;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; rdsel_wr = 0; rddata_wr = 0; rs1sel_fr = 0; rs2sel_fr = 0;
        cycle();
        do_write(5'd5, 32'h1234_5678);
        idle(); rst = 1'b1;
        cycle();
        checks++;
        if (wr_valid_rd !== 1'b0) begin
            errors++; $display("FAIL reset_wv: got %b want 0", wr_valid_rd);
        end
        do_read(5'd5, 5'd0);
        checks++;
        if (rs1data_rd !== 32'h0 || rs2data_rd !== 32'h0) begin
            errors++; $display("FAIL reset_read: got %h/%h want 0/0", rs1data_rd, rs2data_rd);
        end
    endtask

    task automatic test_basic_write();
        do_write(5'd3, 32'h2222_2222);
        checks++;
        if (wr_valid_rd !== 1'b1) begin
            errors++; $display("FAIL basic_wv: got %b want 1", wr_valid_rd);
        end
        do_read(5'd3, 5'd3);
        checks++;
        if (rs1data_rd !== 32'h2222_2222) begin
            errors++; $display("FAIL basic_read: got %h want 22222222", rs1data_rd);
        end
        checks++;
        if (wr_valid_rd !== 1'b0) begin
            errors++; $display("FAIL basic_wv_drop: got %b want 0", wr_valid_rd);
        end
    endtask

    task automatic test_x0();
        do_write(5'd0, 32'hFFFF_FFFF);
        checks++;
        if (wr_valid_rd !== 1'b0) begin
            errors++; $display("FAIL x0_wv: got %b want 0", wr_valid_rd);
        end
        do_read(5'd0, 5'd0);
        checks++;
        if (rs1data_rd !== 32'h0 || rs2data_rd !== 32'h0) begin
            errors++; $display("FAIL x0_read: got %h/%h want 0/0", rs1data_rd, rs2data_rd);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h1111_1111);
        idle();
        phase_writeback = 1'b1; rdsel_wr = 5'd7; rddata_wr = 32'hAAAA_AAAA;
        phase_decode = 1'b1; rs1sel_fr = 5'd7; rs2sel_fr = 5'd7;
        cycle();
        checks++;
        if (rs1data_rd !== 32'hAAAA_AAAA || rs2data_rd !== 32'hAAAA_AAAA) begin
            errors++; $display("FAIL bypass: got %h/%h want aaaaaaaa", rs1data_rd, rs2data_rd);
        end
        idle(); cycle();
        do_read(5'd7, 5'd3);
        checks++;
        if (rs1data_rd !== 32'hAAAA_AAAA || rs2data_rd !== 32'h2222_2222) begin
            errors++; $display("FAIL bypass_later: got %h/%h want aaaaaaaa/22222222",
                               rs1data_rd, rs2data_rd);
        end
    endtask

    task automatic test_phase_gating();
        idle(); rdsel_wr = 5'd9; rddata_wr = 32'h5555_5555;
        cycle();
        checks++;
        if (wr_valid_rd !== 1'b0) begin
            errors++; $display("FAIL gate_wv: got %b want 0", wr_valid_rd);
        end
        do_read(5'd9, 5'd3);
        checks++;
        if (rs1data_rd !== 32'h0) begin
            errors++; $display("FAIL gate_write: got %h want 0", rs1data_rd);
        end
        idle(); rs1sel_fr = 5'd7; rs2sel_fr = 5'd7;
        cycle(); cycle();
        checks++;
        if (rs1data_rd !== 32'h0 || rs2data_rd !== 32'h2222_2222) begin
            errors++; $display("FAIL gate_hold: got %h/%h want 0/22222222", rs1data_rd, rs2data_rd);
        end
    endtask

    task automatic test_reset_mid();
        idle(); rst = 1'b1; phase_writeback = 1'b1; rdsel_wr = 5'd4; rddata_wr = 32'hDEAD_BEEF;
        cycle();
        checks++;
        if (wr_valid_rd !== 1'b0) begin
            errors++; $display("FAIL rstmid_wv: got %b want 0", wr_valid_rd);
        end
        do_read(5'd4, 5'd7);
        checks++;
        if (rs1data_rd !== 32'h0 || rs2data_rd !== 32'h0) begin
            errors++; $display("FAIL rstmid_read: got %h/%h want 0/0", rs1data_rd, rs2data_rd);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst             = ($urandom_range(0, 59) == 0);
            phase_decode    = 1'($urandom);
            phase_writeback = 1'($urandom);
            // A narrow select range makes bypass and overlap hits frequent.
            rdsel_wr        = 5'($urandom_range(0, 7));
            rs1sel_fr       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs2sel_fr       = ($urandom_range(0, 3) == 0) ? rs1sel_fr : 5'($urandom_range(0, 7));
            rddata_wr       = $urandom;
            cycle();
            checks++;
            if (rs1data_rd !== m_rs1 || rs2data_rd !== m_rs2 || wr_valid_rd !== m_wv) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%h/%b want %h/%h/%b", n,
                         rs1data_rd, rs2data_rd, wr_valid_rd, m_rs1, m_rs2, m_wv);
            end
        end
        idle();
        for (int r = 0; r < 32; r++) begin
            do_read(5'(r), 5'(31 - r));
            checks++;
            if (rs1data_rd !== m_rs1 || rs2data_rd !== m_rs2) begin
                errors++;
                $display("FAIL sweep[%0d]: got %h/%h want %h/%h", r,
                         rs1data_rd, rs2data_rd, m_rs1, m_rs2);
            end
        end
    endtask

    initial begin
        idle();
        rdsel_wr = 0; rddata_wr = 0; rs1sel_fr = 0; rs2sel_fr = 0;
        m_rs1 = '0; m_rs2 = '0; m_wv = 1'b0;
        foreach (m_regs[k]) m_regs[k] = '0;
        @(negedge clk);
        test_reset();
        test_basic_write();
        test_x0();
        test_bypass();
        test_phase_gating();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
